ram_initiator: RTL and testbench
================================

// Module: ram_initiator
// PURPOSE
//  Bus-initiator (load/store unit) for the single-port RAM Cs/We/Ack handshake. Accepts one
//  load/store request at a time from the core. Drives Cs/We/Addr/Wdata until Ack is seen.
//  Returns load data sign- or zero-extended by size.
//  Byte and half stores use read-modify-write, because the RAM writes only whole words.
//  Guards every bus access with an Ack timeout.
// PARAMETERS
//  WORD_SIZE  4   bytes per RAM word; the size encoding below assumes 4
//  ADDR_W     10  byte-address width, = clog2(RAM capacity)
//  TIMEOUT    16  max cycles Cs is held without Ack before the access is aborted (>=2)
// PORTS
//  Clk          in   1             clock
//  Rst          in   1             synchronous active-high reset
//  Req_valid    in   1             request present
//  Req_ready    out  1             = (state==IDLE) & ~Rst; request accepted when Req_valid & Req_ready
//  Req_we       in   1             1 store, 0 load
//  Req_size     in   2             0 byte, 1 half, 2 word, 3 illegal
//  Req_unsigned in   1             load: zero-extend when 1, sign-extend when 0; ignored for stores
//  Req_addr     in   ADDR_W        byte address (unaligned allowed)
//  Req_wdata    in   8*WORD_SIZE   store data, right-aligned
//  Resp_valid   out  1             one-cycle completion pulse
//  Resp_err     out  1             qualifies Resp_valid: illegal size or timeout
//  Resp_rdata   out  8*WORD_SIZE   load result; 0 for stores and errors
//  Ram_addr     out  ADDR_W        to RAM Addr
//  Ram_cs       out  1             to RAM Cs
//  Ram_we       out  1             to RAM We
//  Ram_wdata    out  8*WORD_SIZE   to RAM Wdata
//  Ram_rdata    in   8*WORD_SIZE   from RAM Rdata, sampled only when Ram_ack=1 in RD
//  Ram_ack      in   1             from RAM Ack, one-cycle pulse
// BEHAVIOUR
//  Outputs and registers
//   - All outputs are registered except Req_ready.
//   - Reset values: Ram_cs=Ram_we=0; Ram_addr=Ram_wdata=0; Resp_valid=Resp_err=0; Resp_rdata=0.
//   - On accept, latch we, size, unsigned, addr and wdata. Req_* are ignored while busy.
//  States: IDLE, RD (Cs=1, We=0), GAP (Cs=0), WR (Cs=1, We=1), RESP (Resp_valid=1, Cs=0).
//  Transitions
//   - IDLE, accept, size==3:                go to RESP with err=1; no bus access.
//   - IDLE, accept, load:                   go to RD.
//   - IDLE, accept, word store:             go to WR with Ram_wdata = wdata.
//   - IDLE, accept, byte/half store:        go to RD.
//   - RD, Ram_ack, load:                    Resp_rdata <= extend(Ram_rdata); go to RESP.
//   - RD, Ram_ack, store:                   merge into Ram_wdata; go to GAP.
//   - GAP:                                  go to WR (one mandatory Cs-low cycle between accesses).
//   - WR, Ram_ack:                          go to RESP.
//   - RESP:                                 go to IDLE.
//  Data layout (little-endian: byte 0 = Ram_rdata[7:0] = memory[Ram_addr])
//   - Byte load: ext(rd[7:0]). Half load: ext(rd[15:0]). Word load: rd.
//   - Byte merge: {rd[31:8], wdata[7:0]}. Half merge: {rd[31:16], wdata[15:0]}.
//  Timing and handshake
//   - Cs is a registered signal; it drops in the cycle after Ack is seen, so the RAM never re-acks.
//   - Latency from accept to Resp_valid: load 3, word store 3, sub-word store 6, illegal size 1.
//  Timeout
//   - A counter clears on entering RD/WR and increments each RD/WR cycle without Ack.
//   - If no Ack by the TIMEOUT-th cycle: Cs drops, go to RESP with err=1 and rdata=0.
//   - Ack arriving in that same cycle wins over the timeout.
//  Boundary cases
//   - Ram_ack outside RD/WR is ignored.
//   - Rst mid-operation: state goes to IDLE and Cs is low in the next cycle.
//     No Resp_valid is produced for the aborted request.
// TESTING
//  1 Word store 0xDEADBEEF @0x10, then word load @0x10
//    -> one write access; load Resp_rdata=0xDEADBEEF; Resp_valid 3 cycles after each accept.
//  2 Byte store 0x80 @0x10 -> RD, 1 Cs-low cycle, WR; word load -> 0xDEADBE80;
//    signed byte load -> 0xFFFFFF80; unsigned byte load -> 0x00000080.
//  3 Signed half load @0x10 -> 0xFFFFBE80; unsigned half load @0x11 -> 0x0000ADBE (unaligned).
//  4 Req_size=3 -> Resp_valid&Resp_err 1 cycle after accept; Ram_cs never asserted.
//  5 Ram_ack tied 0, TIMEOUT=8, load -> Ram_cs high exactly 8 cycles,
//    then Resp_err=1, Resp_rdata=0, Req_ready returns to 1.
//  6 Rst pulsed in WR -> Ram_cs=0 next cycle, no Resp_valid;
//    Req_valid held during a busy load is not re-accepted until IDLE.

Source files
------------

// File: rtl/ram_initiator.sv
`default_nettype none
// ============================================================================
// ram_initiator: load/store bus initiator for the Cs/We/Ack single-port RAM,
// with sub-word read-modify-write stores and an Ack timeout on every access.
// Revision: 1.0
// ============================================================================
module ram_initiator #(
    parameter int WORD_SIZE = 4,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Req_valid,
    output logic                   Req_ready,
    input  logic                   Req_we,
    input  logic [1:0]             Req_size,
    input  logic                   Req_unsigned,
    input  logic [ADDR_W-1:0]      Req_addr,
    input  logic [8*WORD_SIZE-1:0] Req_wdata,
    output logic                   Resp_valid,
    output logic                   Resp_err,
    output logic [8*WORD_SIZE-1:0] Resp_rdata,
    output logic [ADDR_W-1:0]      Ram_addr,
    output logic                   Ram_cs,
    output logic                   Ram_we,
    output logic [8*WORD_SIZE-1:0] Ram_wdata,
    input  logic [8*WORD_SIZE-1:0] Ram_rdata,
    input  logic                   Ram_ack
);

    localparam int DW = 8 * WORD_SIZE;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        GAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            err_next;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            timed_out;
    logic [DW-1:0]   load_ext;
    logic [DW-1:0]   merged;

    assign Req_ready = (state == IDLE) & ~Rst;
    assign accept    = Req_valid & Req_ready;
    // An Ack in the final allowed cycle takes precedence over the timeout.
    assign timed_out = (cnt == CW'(TIMEOUT - 1)) & ~Ram_ack;

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (Req_size == 2'd3) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end else if (Req_we && Req_size == 2'd2) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (Ram_ack) begin
                    state_next = we_q ? GAP : RESP;
                end else if (timed_out) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
            end
            GAP:  state_next = WR;
            WR: begin
                if (Ram_ack) begin
                    state_next = RESP;
                end else if (timed_out) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ext = Ram_rdata;
        merged   = Ram_rdata;
        case (size_q)
            2'd0: begin
                load_ext = {{(DW-8){~uns_q & Ram_rdata[7]}}, Ram_rdata[7:0]};
                merged   = {Ram_rdata[DW-1:8], Ram_wdata[7:0]};
            end
            2'd1: begin
                load_ext = {{(DW-16){~uns_q & Ram_rdata[15]}}, Ram_rdata[15:0]};
                merged   = {Ram_rdata[DW-1:16], Ram_wdata[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            cnt        <= '0;
            Ram_cs     <= 1'b0;
            Ram_we     <= 1'b0;
            Ram_addr   <= '0;
            Ram_wdata  <= '0;
            Resp_valid <= 1'b0;
            Resp_err   <= 1'b0;
            Resp_rdata <= '0;
        end else begin
            state      <= state_next;
            Ram_cs     <= (state_next == RD) || (state_next == WR);
            Ram_we     <= (state_next == WR);
            Resp_valid <= (state_next == RESP);
            Resp_err   <= err_next;
            Resp_rdata <= (state == RD && Ram_ack && !we_q) ? load_ext : '0;

            if (state_next != state) begin
                cnt <= '0;
            end else if (state == RD || state == WR) begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                we_q     <= Req_we;
                size_q   <= Req_size;
                uns_q    <= Req_unsigned;
                Ram_addr <= Req_addr;
                // Store data parks in Ram_wdata; sub-word stores merge into it after the read.
                if (Req_we) begin
                    Ram_wdata <= Req_wdata;
                end
            end else if (state == RD && Ram_ack && we_q) begin
                Ram_wdata <= merged;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_initiator.sv
`default_nettype none
// tb_ram_initiator: directed and randomized checks of ram_initiator against a
// byte-array memory model, with a behavioural RAM that acks one cycle after Cs.
module tb_ram_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  ram_addr;
    logic        ram_cs, ram_we, ram_ack;
    logic [31:0] ram_wdata, ram_rdata;

    logic [7:0]  mem    [0:1023];
    logic [7:0]  golden [0:1023];
    logic        ack_en;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ram_initiator #(.WORD_SIZE(4), .ADDR_W(10), .TIMEOUT(8)) dut (
        .Clk(clk), .Rst(rst),
        .Req_valid(req_valid), .Req_ready(req_ready), .Req_we(req_we),
        .Req_size(req_size), .Req_unsigned(req_unsigned), .Req_addr(req_addr),
        .Req_wdata(req_wdata),
        .Resp_valid(resp_valid), .Resp_err(resp_err), .Resp_rdata(resp_rdata),
        .Ram_addr(ram_addr), .Ram_cs(ram_cs), .Ram_we(ram_we),
        .Ram_wdata(ram_wdata), .Ram_rdata(ram_rdata), .Ram_ack(ram_ack)
    );

    // RAM: byte-addressed, unaligned word access, single Ack pulse per Cs assertion.
    always @(posedge clk) begin
        if (rst) begin
            ram_ack <= 1'b0;
        end else if (ram_cs && !ram_ack && ack_en) begin
            ram_ack <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                ram_rdata[8*i +: 8] <= mem[(int'(ram_addr) + i) % 1024];
                if (ram_we) mem[(int'(ram_addr) + i) % 1024] <= ram_wdata[8*i +: 8];
            end
        end else begin
            ram_ack <= 1'b0;
        end
    end

    function automatic logic [31:0] ref_load(input logic [9:0] a, input logic [1:0] sz, input logic uns);
        int n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(golden[(int'(a) + i) % 1024]) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) golden[(int'(a) + i) % 1024] = wd[8*i +: 8];
    endtask

    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [9:0] a, input logic [31:0] wd,
                           output int lat, output logic err, output logic [31:0] rd,
                           output int cs_n, output int rises);
        int   w;
        logic prev_cs;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; cs_n = 0; rises = 0; prev_cs = 1'b0; err = 1'b0; rd = '0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (ram_cs) cs_n++;
            if (ram_cs && !prev_cs) rises++;
            prev_cs = ram_cs;
            if (resp_valid) begin
                err = resp_err; rd = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ram_cs !== 1'b0 || ram_we !== 1'b0 || resp_valid !== 1'b0 ||
            resp_err !== 1'b0 || resp_rdata !== 32'h0 || ram_addr !== 10'h0 || ram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready=%b cs=%b we=%b rv=%b re=%b rd=%h addr=%h wd=%h (want 1,0,0,0,0,0,0,0)",
                     req_ready, ram_cs, ram_we, resp_valid, resp_err, resp_rdata, ram_addr, ram_wdata);
        end
    endtask

    // One directed access: expected latency, Cs-high cycle count, Cs rising edges, err, rdata.
    task automatic directed(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [9:0] a, input logic [31:0] wd,
                            input int x_lat, input int x_cs, input int x_rises,
                            input logic x_err, input logic [31:0] x_rd);
        int lat, cs_n, rises;
        logic err;
        logic [31:0] rd;
        run_req(we, sz, uns, a, wd, lat, err, rd, cs_n, rises);
        if (!x_err && we) ref_store(a, sz, wd);
        checks++;
        if (lat !== x_lat || cs_n !== x_cs || rises !== x_rises || err !== x_err || rd !== x_rd) begin
            errors++;
            $display("FAIL %s: lat=%0d cs=%0d rises=%0d err=%b rd=%h, want lat=%0d cs=%0d rises=%0d err=%b rd=%h",
                     nm, lat, cs_n, rises, err, rd, x_lat, x_cs, x_rises, x_err, x_rd);
        end
    endtask

    task automatic test_word;
        directed("word_store", 1'b1, 2'd2, 1'b0, 10'h10, 32'hDEADBEEF, 3, 2, 1, 1'b0, 32'h0);
        directed("word_load",  1'b0, 2'd2, 1'b0, 10'h10, 32'h0,       3, 2, 1, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_subword;
        directed("byte_store",  1'b1, 2'd0, 1'b0, 10'h10, 32'h12345680, 6, 4, 2, 1'b0, 32'h0);
        directed("word_reload", 1'b0, 2'd2, 1'b0, 10'h10, 32'h0, 3, 2, 1, 1'b0, 32'hDEADBE80);
        directed("sbyte_load",  1'b0, 2'd0, 1'b0, 10'h10, 32'h0, 3, 2, 1, 1'b0, 32'hFFFFFF80);
        directed("ubyte_load",  1'b0, 2'd0, 1'b1, 10'h10, 32'h0, 3, 2, 1, 1'b0, 32'h00000080);
        directed("shalf_load",  1'b0, 2'd1, 1'b0, 10'h10, 32'h0, 3, 2, 1, 1'b0, 32'hFFFFBE80);
        directed("uhalf_unal",  1'b0, 2'd1, 1'b1, 10'h11, 32'h0, 3, 2, 1, 1'b0, 32'h0000ADBE);
    endtask

    task automatic test_illegal;
        directed("illegal_ld", 1'b0, 2'd3, 1'b0, 10'h20, 32'h0, 1, 0, 0, 1'b1, 32'h0);
        directed("illegal_st", 1'b1, 2'd3, 1'b0, 10'h20, 32'h55, 1, 0, 0, 1'b1, 32'h0);
    endtask

    task automatic test_timeout;
        ack_en = 1'b0;
        directed("timeout_ld", 1'b0, 2'd2, 1'b0, 10'h10, 32'h0, 9, 8, 1, 1'b1, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready: got %b want 1", req_ready);
        end
        directed("timeout_st", 1'b1, 2'd0, 1'b0, 10'h10, 32'h11, 9, 8, 1, 1'b1, 32'h0);
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int seen;
        ack_en = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h40; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wr: cs=%b we=%b want 1,1", ram_cs, ram_we);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_cs !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_cs: cs=%b ready=%b want 0,0", ram_cs, req_ready);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_resp: resp pulses=%0d ready=%b want 0,1", seen, req_ready);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_busy_hold;
        int lat, ready_busy;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h10; req_wdata = '0;
        req_valid = 1'b1;
        @(posedge clk);
        lat = 0; ready_busy = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (req_ready) ready_busy++;
            if (resp_valid) break;
        end
        @(negedge clk);
        checks++;
        if (lat != 3 || ready_busy != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: lat=%0d ready_while_busy=%0d ready_after=%b want 3,0,1",
                     lat, ready_busy, req_ready);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_random;
        int lat, cs_n, rises, x_lat;
        logic err, we, uns, x_err;
        logic [1:0] sz;
        logic [9:0] a;
        logic [31:0] wd, rd, x_rd;
        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom_range(0, 63));
            wd  = $urandom;
            x_err = (sz == 2'd3);
            x_rd  = (!we && !x_err) ? ref_load(a, sz, uns) : 32'h0;
            x_lat = x_err ? 1 : (we && sz != 2'd2) ? 6 : 3;
            run_req(we, sz, uns, a, wd, lat, err, rd, cs_n, rises);
            if (we && !x_err) ref_store(a, sz, wd);
            checks++;
            if (lat !== x_lat || err !== x_err || rd !== x_rd) begin
                errors++;
                $display("FAIL random[%0d] we=%b sz=%0d uns=%b a=%h: lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                         n, we, sz, uns, a, lat, err, rd, x_lat, x_err, x_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            golden[i] = mem[i];
        end
        ack_en = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_busy_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
